// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Multi-cycle controller for the GSU ALU. Accepts one decoded
//                op at a time, steers the ALU select lines, captures the
//                result and owns the Z/S/CY/OV flag register. The optional
//                second carry/borrow pass for ADC/SBC is enabled by the
//                ALU_CARRY_CHAIN_EN macro. Without the macro, ADC/SBC behave
//                as plain ADD/SUB.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [1:0]       op_alt,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_cy,
    input  logic             alu_ov,
    output logic             y_src_sel,
    output logic [2:0]       z_src_sel,
    output logic             add_sub_sel,
    output logic             x_from_tmp,
    output logic             y_force_one,
    output logic [WIDTH-1:0] result,
    output logic             wb_en,
    output logic             done,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_cy,
    output logic             flag_ov
);

    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_or   = 3'b011;
    localparam logic [2:0] c_op_xor  = 3'b100;
    localparam logic [2:0] c_op_lsr  = 3'b101;
    localparam logic [2:0] c_op_swap = 3'b110;
    localparam logic [2:0] c_op_cmp  = 3'b111;

    localparam logic [2:0] c_z_adder = 3'b000;
    localparam logic [2:0] c_z_and   = 3'b001;
    localparam logic [2:0] c_z_or    = 3'b010;
    localparam logic [2:0] c_z_xor   = 3'b011;
    localparam logic [2:0] c_z_shift = 3'b100;
    localparam logic [2:0] c_z_swap  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_CARRY = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_op_code;
    logic             r_y_imm;
    logic [WIDTH-1:0] r_tmp;
    logic             r_cy1;
    logic             r_ov1;

    logic             w_accept;
    logic             w_is_arith;
    logic             w_is_sub;
    logic [2:0]       w_z_sel;
    logic             w_x_from_tmp;
    logic             w_y_force_one;

    assign w_accept   = op_valid && (r_state == S_IDLE);
    assign w_is_sub   = (r_op_code == c_op_sub) || (r_op_code == c_op_cmp);
    assign w_is_arith = (r_op_code == c_op_add) || w_is_sub;

`ifdef ALU_CARRY_CHAIN_EN
    logic r_with_carry;
    logic w_need_carry;

    // ADC only needs the +1 pass with an incoming carry; SBC only needs the
    // -1 pass with an incoming borrow (flag_cy = 0 means borrow).
    assign w_need_carry = w_is_arith && r_with_carry && (w_is_sub ? !flag_cy : flag_cy);

    // Latch the carry-chain request alongside the other op fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_with_carry <= 1'b0;
        end else if (w_accept) begin
            r_with_carry <= op_alt[0];
        end
    end

    assign x_from_tmp  = w_x_from_tmp;
    assign y_force_one = w_y_force_one;
`else
    assign x_from_tmp  = 1'b0;
    assign y_force_one = 1'b0;
`endif

    // Map latched op onto the ALU result-source select
    always_comb begin
        w_z_sel = c_z_adder;
        case (r_op_code)
            c_op_and:  w_z_sel = c_z_and;
            c_op_or:   w_z_sel = c_z_or;
            c_op_xor:  w_z_sel = c_z_xor;
            c_op_lsr:  w_z_sel = c_z_shift;
            c_op_swap: w_z_sel = c_z_swap;
            default:   w_z_sel = c_z_adder;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and ALU steering outputs
    always_comb begin
        w_state_nxt   = r_state;
        op_ready      = 1'b0;
        y_src_sel     = 1'b0;
        z_src_sel     = c_z_adder;
        add_sub_sel   = 1'b0;
        w_x_from_tmp  = 1'b0;
        w_y_force_one = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                y_src_sel   = r_y_imm;
                z_src_sel   = w_z_sel;
                add_sub_sel = w_is_sub;
`ifdef ALU_CARRY_CHAIN_EN
                w_state_nxt = w_need_carry ? S_CARRY : S_WB;
`else
                w_state_nxt = S_WB;
`endif
            end
`ifdef ALU_CARRY_CHAIN_EN
            S_CARRY: begin
                // Second pass: tmp +/- 1 through the adder
                w_x_from_tmp  = 1'b1;
                w_y_force_one = 1'b1;
                add_sub_sel   = w_is_sub;
                w_state_nxt   = S_WB;
            end
`endif
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: op latch, intermediate capture, result/flag commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_code <= 3'b000;
            r_y_imm   <= 1'b0;
            r_tmp     <= '0;
            r_cy1     <= 1'b0;
            r_ov1     <= 1'b0;
            result    <= '0;
            wb_en     <= 1'b0;
            done      <= 1'b0;
            flag_z    <= 1'b0;
            flag_s    <= 1'b0;
            flag_cy   <= 1'b0;
            flag_ov   <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_code <= op_code;
                        r_y_imm   <= op_alt[1];
                    end
                end
                S_EXEC: begin
                    r_tmp <= alu_z;
                    r_cy1 <= alu_cy;
                    r_ov1 <= alu_ov;
                end
`ifdef ALU_CARRY_CHAIN_EN
                S_CARRY: begin
                    // Carry out of either pass carries; for subtract, no
                    // borrow only if neither pass borrowed.
                    r_tmp <= alu_z;
                    r_cy1 <= w_is_sub ? (r_cy1 & alu_cy) : (r_cy1 | alu_cy);
                    r_ov1 <= r_ov1 | alu_ov;
                end
`endif
                S_WB: begin
                    result <= r_tmp;
                    flag_z <= (r_tmp == '0);
                    flag_s <= r_tmp[WIDTH-1];
                    if (w_is_arith) begin
                        flag_cy <= r_cy1;
                        flag_ov <= r_ov1;
                    end
                    done  <= 1'b1;
                    wb_en <= (r_op_code != c_op_cmp);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
